risc_demux_1to2: RTL

RISC_DEMUX_1TO2 -- requirements
Module: risc_demux_1to2

---
 rtl/risc_demux_pkg.sv | 15 +
 rtl/risc_demux_slot.sv | 38 +++
 rtl/risc_demux_1to2.sv | 72 +++++++
 3 files changed

// File: rtl/risc_demux_pkg.sv
// Shared constants and slot state type for the 1-to-2 valid/ready demultiplexer.
// Optional per-port transfer counters are enabled with RISC_DEMUX_COUNT_EN.
package risc_demux_pkg;

    localparam int   DATA_W = 16;
    localparam logic SEL_A  = 1'b0;
    localparam logic SEL_B  = 1'b1;

    typedef logic slot_state_t;
    localparam slot_state_t EMPTY = 1'b0;
    localparam slot_state_t FULL  = 1'b1;

    localparam int CNT_W = 16;

endpackage

// File: rtl/risc_demux_slot.sv
// Single-entry output register with valid/ready handshake, used once per destination.
//   state | meaning
//   EMPTY | no word held, valid low
//   FULL  | word held on data, valid high until drained
module risc_demux_slot
    import risc_demux_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             drain_ready,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic             space
);

    slot_state_t state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
            data  <= '0;
        end else if (load) begin
            state <= FULL;
            data  <= load_data;
        end else if (state == FULL && drain_ready) begin
            state <= EMPTY;
        end
    end

    assign valid = (state == FULL);
    // a full slot that drains this cycle can take a new word on the same edge
    assign space = (state == EMPTY) || drain_ready;

endmodule

// File: rtl/risc_demux_1to2.sv
// 1-to-2 valid/ready demultiplexer: in_sel routes each word into the A or B output slot.
// Defining RISC_DEMUX_COUNT_EN adds 16-bit per-port output transfer counters.
module risc_demux_1to2
    import risc_demux_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [WIDTH-1:0] a_data,
`ifdef RISC_DEMUX_COUNT_EN
    output logic [CNT_W-1:0] a_count,
    output logic [CNT_W-1:0] b_count,
`endif
    output logic             b_valid,
    input  logic             b_ready,
    output logic [WIDTH-1:0] b_data
);

    logic a_space;
    logic b_space;
    logic in_fire;
    logic load_a;
    logic load_b;

    // only the selected slot gates acceptance, so a stalled port never blocks the other
    assign in_ready = !rst && ((in_sel == SEL_B) ? b_space : a_space);
    assign in_fire  = in_valid && in_ready;
    assign load_a   = in_fire && (in_sel == SEL_A);
    assign load_b   = in_fire && (in_sel == SEL_B);

    risc_demux_slot #(.WIDTH(WIDTH)) u_slot_a (
        .clk         (clk),
        .rst         (rst),
        .load        (load_a),
        .load_data   (in_data),
        .drain_ready (a_ready),
        .valid       (a_valid),
        .data        (a_data),
        .space       (a_space)
    );

    risc_demux_slot #(.WIDTH(WIDTH)) u_slot_b (
        .clk         (clk),
        .rst         (rst),
        .load        (load_b),
        .load_data   (in_data),
        .drain_ready (b_ready),
        .valid       (b_valid),
        .data        (b_data),
        .space       (b_space)
    );

`ifdef RISC_DEMUX_COUNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            a_count <= '0;
            b_count <= '0;
        end else begin
            if (a_valid && a_ready) a_count <= a_count + 1'b1;
            if (b_valid && b_ready) b_count <= b_count + 1'b1;
        end
    end
`endif

endmodule
